// File: rtl/muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide over WIDTH cycles,
// followed by a sign-correction phase and a registered commit into HI/LO.
module muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              fin_q, fin_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d, a_raw_q, a_raw_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              busy_q, busy_d, done_q, done_d;

    // Operand conditioning at start: magnitudes for signed ops, pass-through for unsigned.
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_abs, b_abs;
    assign a_neg = ~mdop[0] & A[WIDTH-1];
    assign b_neg = ~mdop[0] & B[WIDTH-1];
    assign a_abs = a_neg ? (~A + 1'b1) : A;
    assign b_abs = b_neg ? (~B + 1'b1) : B;

    // Multiply step: add multiplicand when the current multiplier bit is set, then shift right.
    logic [WIDTH:0]    mul_sum, mul_hi;
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    assign mul_hi  = acc_lo_q[0] ? mul_sum : {1'b0, acc_hi_q};

    // Restoring divide step: acc_hi is the remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH:0]    div_shift, div_diff;
    logic              no_borrow;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign no_borrow = ~div_diff[WIDTH];

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   div_hi_fix, div_lo_fix;
    always_comb begin
        prod       = {acc_hi_q, acc_lo_q};
        prod_fix   = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
        div_lo_fix = (sa_q ^ sb_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
        div_hi_fix = sa_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        if (mcand_q == '0) begin
            div_lo_fix = '1;
            div_hi_fix = a_raw_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        fin_d    = fin_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mthi) hi_d = A;
                if (mtlo) lo_d = A;
                if (start) begin
                    op_d     = mdop;
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    a_raw_d  = A;
                    acc_hi_d = '0;
                    acc_lo_d = mdop[1] ? a_abs : b_abs;
                    mcand_d  = mdop[1] ? b_abs : a_abs;
                    cnt_d    = CntW'(WIDTH - 1);
                    fin_d    = 1'b0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (op_q[1]) begin
                    acc_hi_d = no_borrow ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], no_borrow};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_hi, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StSign;
            end
            StSign: begin
                // First cycle applies sign correction, second commits to HI/LO.
                if (!fin_q) begin
                    if (op_q[1]) {acc_hi_d, acc_lo_d} = {div_hi_fix, div_lo_fix};
                    else         {acc_hi_d, acc_lo_d} = prod_fix;
                    fin_d = 1'b1;
                end else begin
                    hi_d    = acc_hi_q;
                    lo_d    = acc_lo_q;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Busy covers the cycles after the first in-flight edge up to, not including, done.
        busy_d = (state_q != StIdle) && (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            fin_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            fin_q    <= fin_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed, table-driven bench for muldiv: latency, busy window, results and corner sequences.
module tb_muldiv;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mdop = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .mdop (mdop),
        .A    (A),
        .B    (B),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        string        name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input bit inject, input string name);
        int           lat;
        int           busy_cnt;
        bit           stable;
        logic [W-1:0] prev_hi, prev_lo;
        lat = 0;
        busy_cnt = 0;
        stable = 1'b1;
        @(negedge clk);
        mdop = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; mdop = 2'($urandom_range(3));
        prev_hi = hi; prev_lo = lo;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (inject && c == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; A = 32'hDEAD;
            end else if (inject && c == 6) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
            if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
        end
        check({name, " latency"}, lat, 34);
        check({name, " busy cycles"}, busy_cnt, 33);
        check({name, " hi/lo held"}, stable, 1);
        check({name, " busy in done"}, busy, 0);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7"};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7"};
        vecs[4]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu 5/0"};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min"};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
        vecs[8]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu shift"};
        vecs[9]  = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, "div -8/0"};
        vecs[10] = '{2'b00, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, "mult 5*-1"};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, "divu max/16"};

        repeat (3) @(posedge clk);
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Moves in IDLE.
        @(negedge clk); mthi = 1'b1; A = 32'h1234;
        @(posedge clk); #1; mthi = 1'b0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo untouched", lo, 0);
        @(negedge clk); mtlo = 1'b1; A = 32'h5678;
        @(posedge clk); #1; mtlo = 1'b0;
        check("mtlo lo", lo, 32'h5678);
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; A = 32'hABCD;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo hi", hi, 32'hABCD);
        check("mthi+mtlo lo", lo, 32'hABCD);

        // Table vectors, issued back to back in each done cycle.
        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0,
                   vecs[i].name);

        // start/mthi/mtlo pulsed mid-CALC must be ignored.
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, "inject mid-calc");
        @(posedge clk); #1;
        check("done one cycle", done, 0);
        check("idle after done", busy, 0);

        // start together with mthi: move lands at the start edge, result overwrites later.
        begin
            int lat;
            lat = 0;
            @(negedge clk); mthi = 1'b1; start = 1'b1; mdop = 2'b01; A = 32'd2; B = 32'd3;
            @(posedge clk); #1; mthi = 1'b0; start = 1'b0;
            check("start+mthi hi", hi, 32'd2);
            for (int c = 1; c <= 100; c++) begin
                @(posedge clk); #1;
                if (done) begin
                    lat = c;
                    break;
                end
            end
            check("start+mthi latency", lat, 34);
            check("start+mthi result hi", hi, 0);
            check("start+mthi result lo", lo, 6);
        end

        // Reset in the middle of a MULT abandons it.
        begin
            bit seen_done;
            seen_done = 1'b0;
            @(negedge clk); start = 1'b1; mdop = 2'b00; A = 32'hFFFFFFFD; B = 32'd7;
            @(posedge clk); #1; start = 1'b0;
            repeat (10) @(posedge clk);
            #1; rst = 1'b1;
            #1;
            check("async rst hi", hi, 0);
            check("async rst lo", lo, 0);
            check("async rst busy", busy, 0);
            @(negedge clk); rst = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (done) seen_done = 1'b1;
            end
            check("no done after rst", seen_done, 0);
        end
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
